// File: rtl/core.sv
// core: shared pipeline types and register-file sizing
package core;
  localparam int NUM_REGS = 32;
  localparam int REG_IDX_W = $clog2(NUM_REGS);
  typedef logic [REG_IDX_W-1:0] RegIdx;
  typedef struct packed {
    logic        valid;
    logic [31:0] addr;
    logic [31:0] insn;
  } InsnBundle;
  typedef enum logic [2:0] {HAZ_NONE, HAZ_RAW1, HAZ_RAW2, HAZ_WAW, HAZ_FULL} HazCause;
endpackage

// File: rtl/reg_scoreboard.sv
// reg_scoreboard: busy bit per register with set-wins update and same-cycle writeback bypass
module reg_scoreboard #(
  parameter int NUM_REGS = 32,
  parameter bit ZERO_REG_HW = 1'b1,
  localparam int W = $clog2(NUM_REGS)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            set_en,
  input  logic [W-1:0]    set_idx,
  input  logic            clr_en,
  input  logic [W-1:0]    clr_idx,
  input  logic [2:0][W-1:0] q_idx,
  output logic [2:0]      q_busy
);
  logic [NUM_REGS-1:0] busy, set_mask, clr_mask, eff_busy;
  assign set_mask = (set_en && !(ZERO_REG_HW && set_idx == '0)) ? NUM_REGS'(1) << set_idx : '0;
  assign clr_mask = clr_en ? NUM_REGS'(1) << clr_idx : '0;
  // the register file is write-first, so a retiring writer no longer blocks readers
  assign eff_busy = busy & ~clr_mask;
  always_ff @(posedge clk or posedge rst)
    if (rst) busy <= '0;
    else busy <= (busy & ~clr_mask) | set_mask;
  for (genvar i = 0; i < 3; i++) begin : g_q
    assign q_busy[i] = eff_busy[q_idx[i]];
  end
endmodule

// File: rtl/read_hazard_ctrl.sv
// read_hazard_ctrl: scoreboarded issue control between Decode and the Read stage
module read_hazard_ctrl #(
  parameter int NUM_REGS = core::NUM_REGS,
  parameter int REG_IDX_W = core::REG_IDX_W,
  parameter bit ZERO_REG_HW = 1'b1,
  parameter int TIMEOUT = 1024,
  parameter int STALL_CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  core::InsnBundle        in_insn,
  input  logic [REG_IDX_W-1:0]   in_rs1,
  input  logic                   in_rs1_used,
  input  logic [REG_IDX_W-1:0]   in_rs2,
  input  logic                   in_rs2_used,
  input  logic [REG_IDX_W-1:0]   in_rd,
  input  logic                   in_rd_we,
  output logic                   in_ready,
  output core::InsnBundle        out_insn,
  input  logic                   out_ready,
  input  logic                   wb_valid,
  input  logic [REG_IDX_W-1:0]   wb_rd,
  input  logic                   flush,
  output logic [STALL_CNT_W-1:0] stall_cnt,
  output logic                   err_deadlock
);
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [2:0] q_busy;
  logic hazard, space, stall;
  logic [TW-1:0] timer;
  reg_scoreboard #(.NUM_REGS(NUM_REGS), .ZERO_REG_HW(ZERO_REG_HW)) u_sb (
    .clk(clk), .rst(rst),
    .set_en(in_ready & in_rd_we), .set_idx(in_rd),
    .clr_en(wb_valid), .clr_idx(wb_rd),
    .q_idx({in_rd, in_rs2, in_rs1}), .q_busy(q_busy)
  );
  assign hazard = in_insn.valid & ((in_rs1_used & q_busy[0]) | (in_rs2_used & q_busy[1]) | (in_rd_we & q_busy[2]));
  assign space = ~out_insn.valid | out_ready;
  assign in_ready = in_insn.valid & ~hazard & space & ~flush;
  assign stall = in_insn.valid & ~flush & (hazard | ~space);
  always_ff @(posedge clk or posedge rst)
    if (rst) out_insn <= '0;
    else if (flush) out_insn.valid <= 1'b0;
    else if (in_ready) out_insn <= in_insn;
    else if (out_ready) out_insn.valid <= 1'b0;
  always_ff @(posedge clk or posedge rst)
    if (rst) stall_cnt <= '0;
    else if (hazard & ~flush & ~&stall_cnt) stall_cnt <= stall_cnt + STALL_CNT_W'(1);
  // timer saturates at TIMEOUT; err_deadlock rises on the edge where it gets there
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      timer <= '0;
      err_deadlock <= 1'b0;
    end else begin
      timer <= !stall ? '0 : (timer == TW'(TIMEOUT)) ? timer : timer + TW'(1);
      if (stall && timer == TW'(TIMEOUT - 1)) err_deadlock <= 1'b1;
    end
endmodule

// File: tb/tb_read_hazard_ctrl.sv
// tb_read_hazard_ctrl: directed vectors with hand-computed expectations
module tb_read_hazard_ctrl;
  logic clk = 1'b0, rst = 1'b1;
  core::InsnBundle in_insn, out_insn;
  logic [4:0] in_rs1, in_rs2, in_rd, wb_rd;
  logic in_rs1_used, in_rs2_used, in_rd_we, in_ready, out_ready, wb_valid, flush, err_deadlock;
  logic [7:0] stall_cnt;
  int n_chk = 0, n_fail = 0;

  read_hazard_ctrl #(.TIMEOUT(8), .STALL_CNT_W(8)) dut (
    .clk(clk), .rst(rst), .in_insn(in_insn), .in_rs1(in_rs1), .in_rs1_used(in_rs1_used),
    .in_rs2(in_rs2), .in_rs2_used(in_rs2_used), .in_rd(in_rd), .in_rd_we(in_rd_we),
    .in_ready(in_ready), .out_insn(out_insn), .out_ready(out_ready), .wb_valid(wb_valid),
    .wb_rd(wb_rd), .flush(flush), .stall_cnt(stall_cnt), .err_deadlock(err_deadlock)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [4:0] rs1, input logic u1, input logic [4:0] rs2,
                       input logic u2, input logic [4:0] rd, input logic we, input logic [31:0] addr);
    in_insn = '{valid: v, addr: addr, insn: addr ^ 32'hA5A5_0000};
    in_rs1 = rs1; in_rs1_used = u1; in_rs2 = rs2; in_rs2_used = u2; in_rd = rd; in_rd_we = we;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    out_ready = 1; wb_valid = 0; wb_rd = 0; flush = 0;
    tick; tick;
    check("rst_out_valid", out_insn.valid, 0);
    check("rst_stall_cnt", stall_cnt, 0);
    check("rst_err", err_deadlock, 0);
    rst = 0;
    // RAW stall on r5 released by same-cycle writeback
    drive(1, 0, 0, 0, 0, 5, 1, 32'h100);
    #1 check("i1_ready", in_ready, 1);
    tick;
    check("i1_out_valid", out_insn.valid, 1);
    check("i1_out_addr", out_insn.addr, 32'h100);
    drive(1, 5, 1, 0, 0, 0, 0, 32'h104);
    #1 check("i2_raw1_stall", in_ready, 0);
    tick;
    check("i2_stall_cnt1", stall_cnt, 1);
    check("drain_valid", out_insn.valid, 0);
    drive(1, 0, 0, 5, 1, 0, 0, 32'h104);
    #1 check("raw2_stall", in_ready, 0);
    drive(1, 0, 0, 0, 0, 5, 1, 32'h104);
    #1 check("waw_stall", in_ready, 0);
    drive(1, 5, 1, 0, 0, 0, 0, 32'h104);
    tick;
    check("i2_stall_cnt2", stall_cnt, 2);
    wb_valid = 1; wb_rd = 5;
    #1 check("i2_bypass_ready", in_ready, 1);
    tick;
    wb_valid = 0;
    check("i2_out_valid", out_insn.valid, 1);
    check("i2_out_addr", out_insn.addr, 32'h104);
    check("i2_out_insn", out_insn.insn, 32'hA5A5_0104);
    check("i2_stall_cnt_hold", stall_cnt, 2);
    // back-to-back independent issue
    for (int k = 0; k < 4; k++) begin
      drive(1, 5'(20 + k), 1, 5'(24 + k), 1, 5'(10 + k), 1, 32'h200 + 32'(4 * k));
      #1 check("b2b_ready", in_ready, 1);
      tick;
      check("b2b_out_addr", out_insn.addr, 32'h200 + 32'(4 * k));
    end
    check("b2b_stall_cnt", stall_cnt, 2);
    out_ready = 0;
    drive(1, 1, 1, 2, 1, 3, 1, 32'h280);
    #1 check("full_not_ready", in_ready, 0);
    tick;
    check("hold_valid", out_insn.valid, 1);
    check("hold_addr", out_insn.addr, 32'h20C);
    check("full_no_cnt", stall_cnt, 2);
    out_ready = 1;
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    tick;
    check("drain2_valid", out_insn.valid, 0);
    // set wins over writeback on r10
    drive(1, 0, 0, 0, 0, 10, 1, 32'h300);
    wb_valid = 1; wb_rd = 10;
    #1 check("setwin_ready", in_ready, 1);
    tick;
    wb_valid = 0;
    check("setwin_out_addr", out_insn.addr, 32'h300);
    drive(1, 10, 1, 0, 0, 0, 0, 32'h304);
    #1 check("setwin_busy10", in_ready, 0);
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    tick;
    // r0 never busy; flush drops output, keeps busy bits
    drive(1, 0, 1, 0, 1, 0, 1, 32'h400);
    #1 check("r0_ready", in_ready, 1);
    tick;
    check("r0_out_valid", out_insn.valid, 1);
    drive(1, 0, 1, 0, 1, 0, 1, 32'h404);
    #1 check("r0_not_busy", in_ready, 1);
    flush = 1;
    #1 check("flush_not_ready", in_ready, 0);
    tick;
    flush = 0;
    check("flush_out_valid", out_insn.valid, 0);
    check("flush_stall_cnt", stall_cnt, 2);
    drive(1, 10, 1, 0, 0, 0, 0, 32'h408);
    #1 check("flush_keeps_busy", in_ready, 0);
    // permanent hazard: deadlock after 8 cycles, counter saturation
    repeat (7) tick;
    check("dl_not_yet", err_deadlock, 0);
    check("dl_cnt7", stall_cnt, 9);
    tick;
    check("dl_set", err_deadlock, 1);
    check("dl_cnt8", stall_cnt, 10);
    repeat (300) tick;
    check("sat_cnt", stall_cnt, 8'hFF);
    check("dl_sticky", err_deadlock, 1);
    // async reset between edges
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    tick;
    drive(1, 0, 0, 0, 0, 5, 1, 32'h500);
    #1 check("pre_rst_ready", in_ready, 1);
    tick;
    check("pre_rst_valid", out_insn.valid, 1);
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    #2 rst = 1;
    #1;
    check("arst_out_valid", out_insn.valid, 0);
    check("arst_stall_cnt", stall_cnt, 0);
    check("arst_err", err_deadlock, 0);
    tick;
    rst = 0;
    drive(1, 5, 1, 10, 1, 11, 1, 32'h600);
    #1 check("arst_not_busy", in_ready, 1);
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    tick;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
